// File: rtl/i2c_slave_regport.sv
// I2C target: decodes [slave addr][reg addr][data...] writes into a byte-wide register
// write port and serves repeated-START reads from an external register array.
module i2c_slave_regport #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h39,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       reg_rd_strobe,
  output logic       busy
);
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through sync, filter and edge history.
  logic [1:0]    raw, s1_q, s2_q, f_q, fd_q;
  logic [CW-1:0] cnt_q [2];

  assign raw = {sda_in, scl_in};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '1;
      s2_q <= '1;
      f_q  <= '1;
      fd_q <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      fd_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = f_q[0];
  assign sda_f    = f_q[1];
  assign scl_rise = scl_f & ~fd_q[0];
  assign scl_fall = ~scl_f & fd_q[0];
  // Bus conditions only count while SCL has been high for both samples.
  assign start_c  = scl_f & fd_q[0] & fd_q[1] & ~sda_f;
  assign stop_c   = scl_f & fd_q[0] & ~fd_q[1] & sda_f;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic       rw_q, rw_d, ack_q, ack_d, sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d, rd_stb_q, rd_stb_d;
  logic       load_rd;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_stb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_en_q     <= wr_en_d;
      rd_stb_q    <= rd_stb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_en_d     = 1'b0;
    rd_stb_d    = 1'b0;
    load_rd     = 1'b0;
    if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                rw_d    = sda_f;
                state_d = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
              end else if (state_q == REG) begin
                reg_addr_d = byte_in;
                state_d    = REG_ACK;
              end else begin
                reg_wdata_d = byte_in;
                wr_en_d     = 1'b1;
                state_d     = WDATA_ACK;
              end
            end
          end
        end
        // First fall (end of bit 8) pulls SDA, second fall (end of ACK) releases it.
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                load_rd = 1'b1;
              end else if (state_q == ADDR_ACK) begin
                state_d = REG;
              end else begin
                state_d = WDATA;
                if (state_q == WDATA_ACK) reg_addr_d = reg_addr_q + 8'd1;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ack_d    = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        // Pointer advances at the ACK rise so reg_rdata is valid by the reload fall.
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_d = WAIT_STOP;
            end else begin
              ack_d      = 1'b1;
              reg_addr_d = reg_addr_q + 8'd1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d   = 1'b0;
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_rd) begin
        shift_d   = reg_rdata;
        rd_stb_d  = 1'b1;
        sda_oe_d  = ~reg_rdata[7];
        bit_cnt_d = '0;
        state_d   = RDATA;
      end
    end
  end

  always_comb begin
    busy          = (state_q != IDLE);
    sda_oe        = sda_oe_q;
    reg_addr      = reg_addr_q;
    reg_wdata     = reg_wdata_q;
    reg_wr_en     = wr_en_q;
    reg_rd_strobe = rd_stb_q;
  end
endmodule

// File: tb/tb_i2c_slave_regport.sv
// Directed and randomized I2C transactions against a transaction-level model of the
// register port (pointer arithmetic, expected write/read streams).
module tb_i2c_slave_regport;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, reg_wr_en, reg_rd_strobe, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       sda_line;
  logic [7:0] mem [256];
  logic       glitch_en = 1'b0;
  logic       oe_seen = 1'b0;
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  int n_checks = 0;
  int n_fail = 0;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_slave_regport #(.SLAVE_ADDR(7'h39), .FILTER_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
    .reg_rdata(reg_rdata), .reg_rd_strobe(reg_rd_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_rd_strobe) rd_log.push_back(reg_addr);
    if (sda_oe) oe_seen <= 1'b1;
    if (reg_wr_en || reg_rd_strobe) chk("strobe_excl", {31'd0, reg_wr_en & reg_rd_strobe}, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q / 2);
    if (glitch_en) begin
      sda_m = ~b; tick(1); sda_m = b;
    end
    tick(Q / 2);
    s = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(2 * Q);
    sda_m = 1'b0; tick(2 * Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(2 * Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~mack, s);
  endtask

  // Model: byte i of the payload lands at ptr+i (mod 256); pointer ends at ptr+n.
  task automatic do_write(input string tag, input logic [7:0] ptr, input logic [31:0] dpk, input int n);
    logic ack, all_ack;
    wr_log.delete(); rd_log.delete();
    i2c_start();
    send_byte(8'h72, ack); all_ack = ack;
    send_byte(ptr, ack); all_ack &= ack;
    for (int i = 0; i < n; i++) begin
      send_byte(dpk[8*i +: 8], ack); all_ack &= ack;
    end
    i2c_stop();
    chk({tag, "_ack"}, {31'd0, all_ack}, 1);
    chk({tag, "_nwr"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++)
      chk({tag, "_wr"}, {16'd0, wr_log[i]}, {16'd0, 8'(ptr + i), dpk[8*i +: 8]});
    chk({tag, "_rdn"}, rd_log.size(), 0);
    chk({tag, "_ptr"}, {24'd0, reg_addr}, {24'd0, 8'(ptr + n)});
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Model: byte i returned is mem[ptr+i]; pointer ends on the last byte read.
  task automatic do_read(input string tag, input logic [7:0] ptr, input int n);
    logic ack, all_ack;
    logic [7:0] b;
    wr_log.delete(); rd_log.delete();
    i2c_start();
    send_byte(8'h72, ack); all_ack = ack;
    send_byte(ptr, ack); all_ack &= ack;
    i2c_start();
    send_byte(8'h73, ack); all_ack &= ack;
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      chk({tag, "_data"}, {24'd0, b}, {24'd0, mem[8'(ptr + i)]});
    end
    i2c_stop();
    chk({tag, "_ack"}, {31'd0, all_ack}, 1);
    chk({tag, "_nrd"}, rd_log.size(), n);
    for (int i = 0; i < n && i < rd_log.size(); i++)
      chk({tag, "_rdaddr"}, {24'd0, rd_log[i]}, {24'd0, 8'(ptr + i)});
    chk({tag, "_nwr"}, wr_log.size(), 0);
    chk({tag, "_ptr"}, {24'd0, reg_addr}, {24'd0, 8'(ptr + n - 1)});
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack, s;
    logic [7:0] p;
    logic [31:0] d;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    tick(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {24'd0, reg_addr}, 0);
    chk("rst_wdata", {24'd0, reg_wdata}, 0);
    chk("rst_strobes", {30'd0, reg_wr_en, reg_rd_strobe}, 0);
    reset_n = 1'b1;
    tick(10);

    do_write("wr_basic", 8'h41, 32'h10, 1);
    do_write("wr_wrap", 8'hFF, 32'h55AA, 2);

    mem[8'h08] = 8'hC3;
    mem[8'h09] = 8'h3C;
    do_read("rd_basic", 8'h08, 2);

    // Foreign address: never ACKed, payload ignored until the next START.
    wr_log.delete(); rd_log.delete();
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h74, ack);
    chk("nack_addr", {31'd0, ack}, 0);
    send_byte(8'h41, ack);
    send_byte(8'h10, ack);
    chk("nack_busy", {31'd0, busy}, 1);
    i2c_stop();
    chk("nack_oe", {31'd0, oe_seen}, 0);
    chk("nack_strobes", wr_log.size() + rd_log.size(), 0);
    chk("nack_idle", {31'd0, busy}, 0);

    // Short SDA glitches while SCL is high must not look like START/STOP.
    sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(20);
    chk("glitch_idle", {31'd0, busy}, 0);
    glitch_en = 1'b1;
    do_write("wr_glitch", 8'h5A, 32'h0F81, 2);
    glitch_en = 1'b0;

    // Reset while the target holds the data ACK.
    wr_log.delete();
    i2c_start();
    send_byte(8'h72, ack);
    send_byte(8'h20, ack);
    d = 32'h96;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    sda_m = 1'b1;
    chk("mid_oe_before", {31'd0, sda_oe}, 1);
    chk("mid_wr", wr_log.size(), 1);
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    chk("mid_rst_oe", {31'd0, sda_oe}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_addr", {24'd0, reg_addr}, 0);
    tick(2);
    bit_cycle(1'b1, s);
    i2c_stop();
    do_write("wr_after_rst", 8'h33, 32'hE7, 1);

    for (int k = 0; k < 3; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      d = $urandom;
      do_write("wr_rand", p, d, n);
    end
    for (int k = 0; k < 3; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      do_read("rd_rand", p, n);
    end
    do_read("rd_wrap", 8'hFE, 3);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
